bin2bcd_iter: RTL and testbench
===============================

// Module: bin2bcd_iter
// PURPOSE
//  Parametrised, multi-cycle binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.
//  Start/busy/done handshake; input latched at start; result held in an output register until next done.
//  Flags values that do not fit in DIGITS decimal digits.
//  Feeds the reaction-time display path: counter value in, per-digit BCD out to 7-seg decoders.
// PARAMETERS
//  BIN_W   20  width of binary input; legal >= 1
//  DIGITS   4  number of BCD output digits; legal >= 1
//  (local) CNT_W = $clog2(BIN_W+1)  width of the bit counter
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous reset, active low
//  start        in   1           request conversion; sampled only in IDLE
//  bin          in   BIN_W       unsigned binary value; captured on accepted start
//  busy         out  1           high while a conversion is in progress
//  done         out  1           one-cycle pulse when bcd/overflow update
//  bcd          out  4*DIGITS    result; digit i at bcd[4i+3:4i], digit 0 = units
//  overflow     out  1           result >= 10**DIGITS; bcd then holds value mod 10**DIGITS
//  digit_blank  out  DIGITS      leading-zero blank flags (see CONFIGURATION)
// BEHAVIOUR
//  Clock/reset: single clock clk; reset is asynchronous, active-low (rst_n).
//  Reset: state=IDLE; busy=0, done=0, bcd=0, overflow=0, digit_blank=0; working regs and counter cleared.
//  Reset asserted mid-conversion aborts it immediately; no done pulse; outputs return to reset values.
//  FSM, 2 states:
//   IDLE : busy=0. If start=1 at edge k: shift reg<=bin, work digits<=0, ovf_acc<=0, cnt<=BIN_W, ->SHIFT.
//   SHIFT: busy=1. Each edge: (a) every work digit >=5 gets +3 (4-bit, no carry between digits);
//          (b) {work, shift reg} shifted left 1; bit leaving the top digit OR-ed into ovf_acc;
//          (c) cnt<=cnt-1. Last step (cnt==1): commit corrected+shifted digits to bcd, overflow<=ovf_acc|bit out,
//          done<=1 for one cycle, ->IDLE.
//  Correction precedes the shift on every step, so there is no correction after the final shift.
//  Latency: start accepted at edge k -> bcd/overflow valid and done=1 after edge k+BIN_W.
//  busy high from after edge k until after edge k+BIN_W (falls same edge done rises).
//  start held high continuously: next start accepted at edge k+BIN_W+1; throughput 1 per BIN_W+1 cycles.
//  start while busy: ignored, not queued. bin changes while busy: no effect on current result.
//  bcd/overflow/digit_blank change only on the done edge (or reset); stable otherwise.
//  Overflow: digits below top remain exact; bcd = bin mod 10**DIGITS. DIGITS large enough -> never set.
//  Input 0: bcd=0, overflow=0. BIN_W=1: one shift cycle, latency 1.
// CONFIGURATION
//  Macro BIN2BCD_BLANK_EN:
//   defined  : on done edge, digit_blank[i]=1 iff digit i and all higher digits are 0, for i>=1;
//              digit_blank[0] always 0 (units never blanked); forced 0 when overflow=1.
//   undefined: digit_blank tied to 0; no blanking logic synthesised; all other behaviour identical.
// TESTING
//  1 BIN_W=20,DIGITS=4: bin=1234, start pulse -> done 20 cycles later, bcd=16'h1234, overflow=0, busy low.
//  2 bin=9999 -> bcd=16'h9999, ovf=0; bin=10000 -> bcd=16'h0000, ovf=1; bin=20'hFFFFF -> 16'h8575, ovf=1.
//  3 start at edge k, start re-pulsed at k+5 and bin changed at k+5 -> single done at k+20, result of original bin.
//  4 rst_n low at k+10 of a conversion -> outputs 0 immediately, no done; fresh start after release converts correctly.
//  5 BIN2BCD_BLANK_EN defined: bin=42 -> bcd=16'h0042, blank=4'b1100; bin=0 -> blank=4'b1110;
//    bin=10000 -> blank=4'b0000. Undefined: blank=0 for all.
//  6 start held high, random bin stream; BIN_W=8,DIGITS=3 and BIN_W=20,DIGITS=7 -> done every BIN_W+1 cycles,
//    each bcd matches reference model (value mod 10**DIGITS, overflow flag).

Source files
------------

// File: rtl/bin2bcd_iter_if.sv
// rtl/bin2bcd_iter_if.sv - start/busy/done handshake and result bus of bin2bcd_iter
//
// Purpose: groups the request and result signals of the iterative binary-to-BCD
//   converter so that the converter and its user share a single bundle.
// Parameters:
//   BIN_W   width of the binary input value
//   DIGITS  number of BCD result digits
// Signals:
//   start        request a conversion (driven by master)
//   bin          unsigned binary value, captured on an accepted start (master)
//   busy         conversion in progress (slave)
//   done         one-cycle pulse when bcd/overflow/digit_blank update (slave)
//   bcd          result digits, digit 0 = units in bcd[3:0] (slave)
//   overflow     value did not fit in DIGITS digits (slave)
//   digit_blank  leading-zero blank flags per digit (slave)
// Modports: master = requester, slave = converter.

interface bin2bcd_iter_if #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 4
) ();

  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
  logic [DIGITS-1:0]     digit_blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow, digit_blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow, digit_blank
  );

endinterface

// File: rtl/bin2bcd_iter.sv
// rtl/bin2bcd_iter.sv - multi-cycle shift-add-3 binary-to-BCD converter, one bit per clock
//
// Purpose: converts an unsigned BIN_W-bit value into DIGITS BCD digits using the
//   double-dabble algorithm, one input bit per clock. The input is latched when
//   start is accepted in IDLE; the result is held until the next done pulse.
//   Values >= 10**DIGITS raise overflow and leave value mod 10**DIGITS in bcd.
// Parameters:
//   BIN_W   width of binary input (>= 1)
//   DIGITS  number of BCD output digits (>= 1)
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active low
//   bus    bin2bcd_iter_if.slave: start, bin in; busy, done, bcd, overflow,
//          digit_blank out
// Configuration:
//   BIN2BCD_BLANK_EN  when defined, digit_blank[i] (i >= 1) is set on the done edge
//                     if digit i and all higher digits are zero; digit 0 is never
//                     blanked and all flags are cleared on overflow. When undefined,
//                     digit_blank is tied to zero.

module bin2bcd_iter #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bin2bcd_iter_if.slave     bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_nxt;

  logic [BIN_W-1:0]   sreg;
  logic [BCD_W-1:0]   work;
  logic               ovf_acc;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               done_q;

  logic               load;
  logic               step;
  logic               last;

  logic [BCD_W-1:0]   corrected;
  logic [BCD_W-1:0]   work_nxt;
  logic               bit_out;
  logic               ovf_final;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction happens before each shift; digits are independent 4-bit
  // adds because a digit >= 5 plus 3 never exceeds 4'hC.
  always_comb begin
    corrected = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        corrected[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit shifted out of the top digit is a lost decimal weight: overflow.
  assign bit_out   = corrected[BCD_W-1];
  assign work_nxt  = {corrected[BCD_W-2:0], sreg[BIN_W-1]};
  assign ovf_final = ovf_acc | bit_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      work    <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        sreg    <= bus.bin;
        work    <= '0;
        ovf_acc <= 1'b0;
        cnt     <= CNT_W'(BIN_W);
      end
      if (step) begin
        sreg    <= sreg << 1;
        work    <= work_nxt;
        ovf_acc <= ovf_final;
        cnt     <= cnt - CNT_W'(1);
      end
      if (last) begin
        bcd_q  <= work_nxt;
        ovf_q  <= ovf_final;
        done_q <= 1'b1;
      end
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic [DIGITS-1:0] blank_q;
  logic              higher_zero;

  // Walk from the top digit down; a digit is blanked only while every digit
  // above it is also zero. Units digit stays visible so 0 shows as "0".
  always_comb begin
    blank_nxt   = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higher_zero  = higher_zero & (work_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = higher_zero;
    end
    if (ovf_final) begin
      blank_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (last) begin
      blank_q <= blank_nxt;
    end
  end

  assign bus.digit_blank = blank_q;
`else
  assign bus.digit_blank = '0;
`endif

  assign bus.busy     = (state == SHIFT);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// tb/tb_bin2bcd_iter.sv - scoreboard bench for bin2bcd_iter

module tb_bin2bcd_iter;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    logic [7:0]  blank;
    int          cyc;
  } exp_t;

  exp_t q20[$];
  exp_t q8[$];

  bin2bcd_iter_if #(.BIN_W(20), .DIGITS(4)) bus20 ();
  bin2bcd_iter_if #(.BIN_W(8),  .DIGITS(3)) bus8 ();

  bin2bcd_iter #(.BIN_W(20), .DIGITS(4)) dut20 (.clk(clk), .rst_n(rst_n), .bus(bus20.slave));
  bin2bcd_iter #(.BIN_W(8),  .DIGITS(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] bl(input logic [7:0] b);
`ifdef BIN2BCD_BLANK_EN
    return b;
`else
    return 8'h00 & b;
`endif
  endfunction

  // Monitors: pop the next expectation whenever a done pulse is presented.
  always @(negedge clk) begin
    if (rst_n && bus20.done) begin
      if (q20.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done20: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q20.pop_front();
        check("bcd20", 32'(bus20.bcd), e.bcd);
        check("ovf20", 32'(bus20.overflow), 32'(e.ovf));
        check("blank20", 32'(bus20.digit_blank), 32'(e.blank[3:0]));
        check("done_cyc20", 32'(cyc), 32'(e.cyc));
        check("busy_at_done20", 32'(bus20.busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.done) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done8: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("bcd8", 32'(bus8.bcd), e.bcd);
        check("ovf8", 32'(bus8.overflow), 32'(e.ovf));
        check("blank8", 32'(bus8.digit_blank), 32'(e.blank[2:0]));
        check("done_cyc8", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one start pulse on the 20/4 instance; push the expectation if asked.
  task automatic issue20(input logic [19:0] v, input logic [15:0] eb, input logic eo,
                         input logic [3:0] ebl, input bit expect_done, output int acc);
    int n;
    n = 0;
    while (bus20.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'd1, 32'd0);
    bus20.start = 1'b1;
    bus20.bin   = v;
    acc = cyc + 1;
    if (expect_done) q20.push_back('{bcd: 32'(eb), ovf: eo, blank: bl(8'(ebl)), cyc: acc + 20});
    @(posedge clk); #1;
    bus20.start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q20.size() != 0 || q8.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check(name, 32'(q20.size() + q8.size()), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] vb [9];
  logic [19:0] vv [9];
  logic        vo [9];
  logic [3:0]  vl [9];
  logic [7:0]  sv [6];
  logic [11:0] sb [6];
  logic [2:0]  sl [6];

  initial begin
    int acc;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    bus20.start = 1'b0;
    bus20.bin   = '0;
    bus8.start  = 1'b0;
    bus8.bin    = '0;

    vv = '{20'd1234, 20'd9999, 20'd10000, 20'hFFFFF, 20'd42, 20'd0, 20'd7, 20'd305, 20'd12345};
    vb = '{16'h1234, 16'h9999, 16'h0000, 16'h8575, 16'h0042, 16'h0000, 16'h0007, 16'h0305, 16'h2345};
    vo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vl = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1110, 4'b1110, 4'b1000, 4'b0000};

    sv = '{8'd0, 8'd255, 8'd99, 8'd100, 8'd200, 8'd37};
    sb = '{12'h000, 12'h255, 12'h099, 12'h100, 12'h200, 12'h037};
    sl = '{3'b110, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus20.busy), 32'd0);
    check("rst_done", 32'(bus20.done), 32'd0);
    check("rst_bcd", 32'(bus20.bcd), 32'd0);
    check("rst_ovf", 32'(bus20.overflow), 32'd0);
    check("rst_blank", 32'(bus20.digit_blank), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed single conversions.
    for (int i = 0; i < 9; i++) begin
      issue20(vv[i], vb[i], vo[i], vl[i], 1'b1, acc);
      check("busy_after_accept", 32'(bus20.busy), 32'd1);
    end
    drain("drain_directed");

    // Re-pulsed start and changed bin mid-conversion must not disturb the result.
    issue20(20'd555, 16'h0555, 1'b0, 4'b1000, 1'b1, acc);
    while (cyc < acc + 5) begin
      @(posedge clk); #1;
    end
    bus20.start = 1'b1;
    bus20.bin   = 20'd777;
    @(posedge clk); #1;
    bus20.start = 1'b0;
    drain("drain_repulse");
    repeat (25) @(posedge clk);
    #1;

    // Reset mid-conversion aborts with no done; outputs return to zero.
    issue20(20'd4321, 16'h0, 1'b0, 4'b0, 1'b0, acc);
    while (cyc < acc + 10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bus20.bcd), 32'd0);
    check("abort_busy", 32'(bus20.busy), 32'd0);
    check("abort_done", 32'(bus20.done), 32'd0);
    check("abort_ovf", 32'(bus20.overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    issue20(20'd4321, 16'h4321, 1'b0, 4'b0000, 1'b1, acc);
    drain("drain_after_reset");

    // Held start on the 8/3 instance: one result every 9 cycles.
    @(posedge clk); #1;
    bus8.start = 1'b1;
    acc = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      bus8.bin = sv[i];
      q8.push_back('{bcd: 32'(sb[i]), ovf: 1'b0, blank: bl(8'(sl[i])), cyc: acc + 8});
      repeat (9) @(posedge clk);
      #1;
      acc = acc + 9;
    end
    bus8.start = 1'b0;
    drain("drain_stream");
    repeat (12) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
